// File: rtl/datapath_pkg.sv
// Shared encodings for the multi-cycle datapath controller: opcodes, functs,
// ALU control codes, FSM states and the decoder's classification result.
package datapath_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
   } state_e;

   typedef enum logic [2:0] {
      C_RTYPE, C_LW, C_SW, C_ADDI, C_BEQ, C_ILLEGAL
   } iclass_e;

   typedef struct packed {
      iclass_e    cls;
      logic [2:0] alu;
   } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational classifier: opcode/funct -> instruction class and ALU code.
module instr_decoder
   import datapath_pkg::*;
#(
   parameter int OPC_W = 6
) (
   input  logic [OPC_W-1:0] opcode_i,
   input  logic [OPC_W-1:0] funct_i,
   output dec_t             dec_o
);

   always_comb begin
      dec_o.cls = C_ILLEGAL;
      dec_o.alu = ALU_ADD;
      case (opcode_i)
         OPC_W'(OP_RTYPE): begin
            dec_o.cls = C_RTYPE;
            case (funct_i)
               OPC_W'(FN_ADD): dec_o.alu = ALU_ADD;
               OPC_W'(FN_SUB): dec_o.alu = ALU_SUB;
               OPC_W'(FN_AND): dec_o.alu = ALU_AND;
               OPC_W'(FN_OR):  dec_o.alu = ALU_OR;
               OPC_W'(FN_SLT): dec_o.alu = ALU_SLT;
               default:        dec_o.cls = C_ILLEGAL;
            endcase
         end
         OPC_W'(OP_LW):   dec_o.cls = C_LW;
         OPC_W'(OP_SW):   dec_o.cls = C_SW;
         OPC_W'(OP_ADDI): dec_o.cls = C_ADDI;
         OPC_W'(OP_BEQ): begin
            dec_o.cls = C_BEQ;
            dec_o.alu = ALU_SUB;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle controller sequencing the datapath through DECODE/EXEC/MEM/WB
// for one captured instruction; Moore outputs come from state + instr_q.
module datapath_ctrl_fsm
   import datapath_pkg::*;
#(
   parameter int OPC_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [31:0]      i_instr,
   input  logic             i_zero,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_illegal,
   output logic             o_branch_taken,
   output logic [4:0]       o_first5bits,
   output logic [4:0]       o_second5bits,
   output logic [4:0]       o_third5bits,
   output logic [15:0]      o_immediate,
   output logic             o_regDst,
   output logic             o_ReadWriteRF,
   output logic             o_RFSource,
   output logic             o_AluSource,
   output logic [2:0]       o_AluControl,
   output logic             o_WriteEnDataMemory,
   output logic             o_ReadEnDataMemory,
   output logic             o_MemToReg,
   output logic [CNT_W-1:0] o_instr_count
);

   state_e            state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic              taken_q, taken_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   dec_t              dec;
   logic              in_exwb;

   instr_decoder #(.OPC_W(OPC_W)) u_dec (
      .opcode_i (instr_q[31 -: OPC_W]),
      .funct_i  (instr_q[OPC_W-1:0]),
      .dec_o    (dec)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         taken_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         taken_q <= taken_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      taken_d = taken_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               instr_d = i_instr;
               taken_d = 1'b0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = (dec.cls == C_ILLEGAL) ? S_DONE : S_EXEC;
         S_EXEC: begin
            if (dec.cls == C_BEQ) taken_d = i_zero;
            case (dec.cls)
               C_RTYPE, C_ADDI: state_d = S_WB;
               C_LW, C_SW:      state_d = S_MEM;
               default:         state_d = S_DONE;
            endcase
         end
         S_MEM: state_d = (dec.cls == C_LW) ? S_WB : S_DONE;
         S_WB:  state_d = S_DONE;
         S_DONE: begin
            state_d = S_IDLE;
            if (dec.cls != C_ILLEGAL) cnt_d = cnt_q + CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ALU code and operand selects stay stable EXEC..WB so the write-back
   // address/result seen by the datapath does not move under the strobe.
   assign in_exwb = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

   always_comb begin
      o_busy              = (state_q != S_IDLE);
      o_done              = (state_q == S_DONE);
      o_illegal           = (state_q == S_DONE) && (dec.cls == C_ILLEGAL);
      o_branch_taken      = (state_q == S_DONE) && taken_q;
      o_first5bits        = instr_q[25:21];
      o_second5bits       = instr_q[20:16];
      o_third5bits        = instr_q[15:11];
      o_immediate         = instr_q[15:0];
      o_regDst            = in_exwb && (dec.cls == C_RTYPE);
      o_ReadWriteRF       = (state_q == S_WB);
      o_RFSource          = 1'b0;
      o_AluSource         = in_exwb && ((dec.cls == C_LW) || (dec.cls == C_SW) ||
                                        (dec.cls == C_ADDI));
      o_AluControl        = in_exwb ? dec.alu : 3'b000;
      o_WriteEnDataMemory = (state_q == S_MEM) && (dec.cls == C_SW);
      o_ReadEnDataMemory  = ((state_q == S_MEM) || (state_q == S_WB)) && (dec.cls == C_LW);
      o_MemToReg          = (state_q == S_WB) && (dec.cls == C_LW);
      o_instr_count       = cnt_q;
   end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Bench: controller drives a small behavioural datapath; results are checked
// cycle by cycle against a phase-path model and an architectural ISA model.
module tb_datapath_ctrl_fsm;

   localparam int CW = 4;
   localparam int K_R = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_BEQ = 4, K_ILL = 5;

   typedef struct packed {
      logic       busy, done, illegal, taken, regdst, rwrf, rfsrc, alusrc;
      logic [2:0] aluctl;
      logic       wem, rem, m2r;
   } out_t;

   typedef struct {
      logic [31:0] in;
      int          edone;
      int          eill;
      int          etk;
   } vec_t;

   logic clk = 1'b0, rst, start, zero, preload;
   logic [31:0] instr;
   logic busy, done, illegal, taken, regdst, rwrf, rfsrc, alusrc, wem, rem, m2r;
   logic [4:0] f1, f2, f3;
   logic [15:0] imm;
   logic [2:0] aluctl;
   logic [CW-1:0] cnt;

   int nchk = 0, nerr = 0, exp_cnt = 0;
   logic [31:0] a_rf [32];
   logic [31:0] a_dm [16];

   always #5 clk = ~clk;

   datapath_ctrl_fsm #(.OPC_W(6), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_instr(instr), .i_zero(zero),
      .o_busy(busy), .o_done(done), .o_illegal(illegal), .o_branch_taken(taken),
      .o_first5bits(f1), .o_second5bits(f2), .o_third5bits(f3), .o_immediate(imm),
      .o_regDst(regdst), .o_ReadWriteRF(rwrf), .o_RFSource(rfsrc), .o_AluSource(alusrc),
      .o_AluControl(aluctl), .o_WriteEnDataMemory(wem), .o_ReadEnDataMemory(rem),
      .o_MemToReg(m2r), .o_instr_count(cnt)
   );

   // Behavioural datapath driven purely by the controller's outputs.
   logic [31:0] rf [32];
   logic [31:0] dm [16];
   logic [31:0] opb, alu_y;
   logic [4:0]  wdst;
   always_comb begin
      opb = alusrc ? {{16{imm[15]}}, imm} : rf[f2];
      case (aluctl)
         3'b000:  alu_y = rf[f1] & opb;
         3'b001:  alu_y = rf[f1] | opb;
         3'b110:  alu_y = rf[f1] - opb;
         3'b111:  alu_y = ($signed(rf[f1]) < $signed(opb)) ? 32'd1 : 32'd0;
         default: alu_y = rf[f1] + opb;
      endcase
      wdst = regdst ? f3 : f2;
   end
   assign zero = (alu_y == 32'd0);

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
         for (int i = 0; i < 16; i++) dm[i] <= 32'd0;
      end else begin
         if (wem) dm[alu_y[5:2]] <= rf[f2];
         if (rwrf && wdst != 5'd0) rf[wdst] <= m2r ? dm[alu_y[5:2]] : alu_y;
      end
   end

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] im);
      return {op, 5'(rs), 5'(rt), im};
   endfunction

   function automatic int kind_of(logic [31:0] in);
      logic [5:0] op, fn;
      op = in[31:26];
      fn = in[5:0];
      if (op == 6'b000000)
         return (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                 fn == 6'b100101 || fn == 6'b101010) ? K_R : K_ILL;
      if (op == 6'b100011) return K_LW;
      if (op == 6'b101011) return K_SW;
      if (op == 6'b001000) return K_ADDI;
      if (op == 6'b000100) return K_BEQ;
      return K_ILL;
   endfunction

   function automatic logic [2:0] alu_of(logic [31:0] in);
      int k;
      k = kind_of(in);
      if (k == K_BEQ) return 3'b110;
      if (k != K_R) return 3'b010;
      case (in[5:0])
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Phase path, one letter per cycle from cycle 1: D decode, E exec, M mem, W wb, F done.
   function automatic string path_of(logic [31:0] in);
      case (kind_of(in))
         K_R, K_ADDI: return "DEWF";
         K_LW:        return "DEMWF";
         K_SW:        return "DEMF";
         K_BEQ:       return "DEF";
         default:     return "DF";
      endcase
   endfunction

   function automatic out_t exp_at(byte ph, logic [31:0] in, bit tk);
      out_t e;
      int   k;
      k = kind_of(in);
      e = '0;
      e.busy = 1'b1;
      if (ph == "E" || ph == "M" || ph == "W") begin
         e.aluctl = alu_of(in);
         e.regdst = (k == K_R);
         e.alusrc = (k == K_LW || k == K_SW || k == K_ADDI);
      end
      if (ph == "W") begin
         e.rwrf = 1'b1;
         e.m2r  = (k == K_LW);
      end
      e.wem = (ph == "M") && (k == K_SW);
      e.rem = (k == K_LW) && (ph == "M" || ph == "W");
      if (ph == "F") begin
         e.done    = 1'b1;
         e.illegal = (k == K_ILL);
         e.taken   = tk;
      end
      return e;
   endfunction

   function automatic out_t act_out();
      out_t a;
      a = '{busy, done, illegal, taken, regdst, rwrf, rfsrc, alusrc, aluctl, wem, rem, m2r};
      return a;
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      nchk++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic arch_apply(logic [31:0] in);
      int rs, rt, rd, k;
      logic [31:0] a, b, sx, res;
      rs = int'(in[25:21]); rt = int'(in[20:16]); rd = int'(in[15:11]);
      sx = {{16{in[15]}}, in[15:0]};
      a = a_rf[rs]; b = a_rf[rt];
      k = kind_of(in);
      case (k)
         K_R: begin
            case (in[5:0])
               6'b100010: res = a - b;
               6'b100100: res = a & b;
               6'b100101: res = a | b;
               6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default:   res = a + b;
            endcase
            if (rd != 0) a_rf[rd] = res;
         end
         K_LW:   if (rt != 0) a_rf[rt] = a_dm[4'((a + sx) >> 2)];
         K_SW:   a_dm[4'((a + sx) >> 2)] = b;
         K_ADDI: if (rt != 0) a_rf[rt] = a + sx;
         default: ;
      endcase
      if (k != K_ILL) exp_cnt = (exp_cnt + 1) % (1 << CW);
   endtask

   task automatic chk_state(string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) if (rf[i] !== a_rf[i]) bad++;
      for (int i = 0; i < 16; i++) if (dm[i] !== a_dm[i]) bad++;
      chk(name, 64'(bad), 64'd0);
   endtask

   // Runs one instruction; edone > 0 additionally pins done/illegal/taken to that cycle.
   task automatic run_instr(logic [31:0] in, int edone, int eill, int etk, bit poke);
      string path;
      bit    tk;
      path = path_of(in);
      tk = (kind_of(in) == K_BEQ) && (a_rf[in[25:21]] == a_rf[in[20:16]]);
      instr = in;
      start = 1'b1;
      @(posedge clk); #1;
      start = poke;
      instr = $urandom;
      for (int k = 1; k <= path.len(); k++) begin
         if (k == path.len()) start = 1'b0;
         chk($sformatf("phase_%s_c%0d", path, k), 64'(act_out()), 64'(exp_at(path[k-1], in, tk)));
         if (k == 1)
            chk("fields", {f1, f2, f3, imm}, {in[25:21], in[20:16], in[15:11], in[15:0]});
         if (edone > 0 && k == edone)
            chk("done_cycle", {done, illegal, taken}, {1'b1, 1'(eill), 1'(etk)});
         @(posedge clk); #1;
      end
      arch_apply(in);
      chk("idle_after", {busy, done}, 2'b00);
      chk("instr_count", 64'(cnt), 64'(exp_cnt));
      chk_state("arch_state");
   endtask

   vec_t tbl[$];
   logic [5:0] fns [5];

   initial begin
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      for (int i = 0; i < 32; i++) a_rf[i] = 32'(i);
      for (int i = 0; i < 16; i++) a_dm[i] = 32'd0;
      rst = 1'b1; start = 1'b0; instr = '0; preload = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      preload = 1'b0;
      chk("reset_outputs", {act_out(), f1, f2, f3, imm, cnt}, '0);

      // Reset beats a simultaneous start.
      start = 1'b1; instr = r_ins(2, 3, 1, 6'b100000);
      @(posedge clk); #1;
      chk("rst_vs_start", {busy, done}, 2'b00);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      chk("rst_vs_start_idle", busy, 1'b0);

      // Reset during MEM of sw: the MEM-cycle write lands, nothing after it.
      instr = i_ins(6'b101011, 0, 10, 16'd16); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("sw_mem_strobe", {wem, rem}, 2'b10);
      rst = 1'b1;
      @(posedge clk); #1;
      a_dm[4] = a_rf[10];
      chk("rst_mid_outputs", {act_out(), f1, f2, f3, imm, cnt}, '0);
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_mid_idle", {busy, wem, 4'(cnt)}, '0);
      chk_state("rst_mid_mem");

      // Directed table: expected done cycle, illegal, taken from the timing rules.
      tbl.push_back('{r_ins(2, 3, 1, 6'b100000), 4, 0, 0});    // add r1=r2+r3
      tbl.push_back('{i_ins(6'b101011, 4, 7, 16'd8), 4, 0, 0}); // sw r7,8(r4)
      tbl.push_back('{i_ins(6'b100011, 4, 9, 16'd8), 5, 0, 0}); // lw r9,8(r4)
      tbl.push_back('{i_ins(6'b000100, 5, 5, 16'd3), 3, 0, 1}); // beq r5,r5
      tbl.push_back('{i_ins(6'b000100, 5, 6, 16'd3), 3, 0, 0}); // beq r5,r6
      tbl.push_back('{{6'b111111, 26'h1234567}, 2, 1, 0});
      tbl.push_back('{r_ins(12, 2, 11, 6'b100010), 4, 0, 0});
      tbl.push_back('{r_ins(13, 6, 14, 6'b100100), 4, 0, 0});
      tbl.push_back('{r_ins(13, 6, 15, 6'b100101), 4, 0, 0});
      tbl.push_back('{r_ins(11, 3, 16, 6'b101010), 4, 0, 0});
      tbl.push_back('{i_ins(6'b001000, 3, 17, 16'hFFF0), 4, 0, 0});
      tbl.push_back('{r_ins(1, 2, 3, 6'b000111), 2, 1, 0});
      foreach (tbl[i]) begin
         run_instr(tbl[i].in, tbl[i].edone, tbl[i].eill, tbl[i].etk, 1'b0);
         if (i == 0) chk("add_r1", rf[1], 32'd5);
         if (i == 2) chk("lw_r9", rf[9], 32'd7);
      end

      // Random stream, start poked while busy half the time.
      for (int n = 0; n < 40; n++) begin
         logic [31:0] in;
         int rs, rt, rd;
         rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
         case ($urandom_range(0, 6))
            0:       in = r_ins(rs, rt, rd, fns[$urandom_range(0, 4)]);
            1:       in = i_ins(6'b100011, rs, rt, 16'($urandom));
            2:       in = i_ins(6'b101011, rs, rt, 16'($urandom));
            3:       in = i_ins(6'b001000, rs, rt, 16'($urandom));
            4:       in = i_ins(6'b000100, rs, ($urandom_range(0, 1) != 0) ? rs : rt, 16'($urandom));
            5:       in = {6'b110000 | 6'($urandom_range(0, 15)), 26'($urandom)};
            default: in = r_ins(rs, rt, rd, 6'($urandom_range(0, 31)));
         endcase
         run_instr(in, 0, 0, 0, 1'($urandom_range(0, 1)));
      end

      // Counter wrap at all-ones.
      for (int g = 0; g < 20 && exp_cnt != (1 << CW) - 1; g++)
         run_instr(i_ins(6'b001000, $urandom_range(0, 31), $urandom_range(1, 31), 16'($urandom)),
                   4, 0, 0, 1'b0);
      chk("count_all_ones", 64'(cnt), 64'((1 << CW) - 1));
      run_instr(r_ins(2, 3, 20, 6'b100000), 4, 0, 0, 1'b0);
      chk("count_wrap", 64'(cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/datapath_ctrl_fsm.md
# datapath_ctrl_fsm

Multi-cycle control unit that sequences the single-instruction `Datapath` (register file, ALU, data memory) through the DECODE, EXEC, MEM and WB phases. It accepts one 32-bit MIPS-style instruction per start handshake and drives every datapath control input. This replaces hand-driven control from the bench. It reports completion, branch outcome and illegal opcodes, and keeps a retired-instruction count.

## Interface
- `OPC_W`, default 6: opcode/funct field width.
- `CNT_W`, default 16: retired-instruction counter width.

Ports:
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  instruction valid; sampled only in IDLE.
- `i_instr`  in  32  instruction; captured on an accepted start.
- `i_zero`  in  1  ALU zero flag from the datapath; sampled in EXEC.
- `o_busy`  out  1  high from the cycle after acceptance until DONE.
- `o_done`  out  1  one-cycle pulse in DONE.
- `o_illegal`  out  1  valid with `o_done`; opcode or funct unsupported.
- `o_branch_taken`  out  1  valid with `o_done`; beq with `i_zero`=1.
- `o_first5bits`, `o_second5bits`  out  5  rs and rt fields of the captured instruction.
- `o_third5bits`  out  5  rd field of the captured instruction.
- `o_immediate`  out  16  immediate field of the captured instruction.
- `o_regDst`  out  1  1 selects rd as the write register, 0 selects rt.
- `o_ReadWriteRF`  out  1  register-file write enable.
- `o_RFSource`  out  1  always 0, selecting datapath data rather than external write data.
- `o_AluSource`  out  1  1 selects the sign-extended immediate as ALU operand B.
- `o_AluControl`  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `o_WriteEnDataMemory`, `o_ReadEnDataMemory`  out  1  data-memory write and read strobes.
- `o_MemToReg`  out  1  1 selects data memory as the write-back source.
- `o_instr_count`  out  CNT_W  count of retired legal instructions; wraps to 0.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB, DONE. Moore outputs are decoded from the state register plus the captured instruction register.
- IDLE: when `i_start`=1, capture `i_instr` and go to DECODE.
- DECODE: classify the instruction and go to EXEC. An illegal instruction goes to DONE with `o_illegal`=1.
- Supported instructions:
  - R-type (opcode 000000) with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Path: EXEC, WB (regDst=1, AluSource=0).
  - lw (100011). Path: EXEC, MEM (read), WB (MemToReg=1, regDst=0).
  - sw (101011). Path: EXEC, MEM (write), DONE.
  - addi (001000). Path: EXEC, WB (AluSource=1, regDst=0).
  - beq (000100). Path: EXEC (SUB), DONE; `o_branch_taken` = `i_zero` registered in EXEC.
- `o_AluControl` is held from EXEC through WB. It is ADD for lw, sw and addi.
- Strobe rules:
  - `o_ReadWriteRF` is high only in WB.
  - `o_WriteEnDataMemory` is high only in MEM of sw.
  - `o_ReadEnDataMemory` is high in MEM of lw and held through WB.
  - Each strobe is active for exactly one cycle, except the lw read strobe.
- DONE: pulse `o_done`, then return to IDLE. Increment `o_instr_count` in DONE only when `o_illegal`=0.
- `i_start` is ignored outside IDLE, and no instruction is queued.

## Timing
- Cycle 0 is the rising edge at which `i_start` is sampled in IDLE. DECODE is cycle 1.
- `o_done` cycle: R-type/addi 4, lw 5, sw 4, beq 3, illegal 2.
- `o_busy` is high from cycle 1 through the `o_done` cycle. The earliest next acceptance is the edge after DONE.
- Reset values: all outputs 0, including `o_AluControl`=000, `o_instr_count`=0 and all field outputs. State is IDLE.
- `i_rst` mid-instruction: the next edge forces IDLE and clears every strobe. There is no partial write after that edge, and the count is unchanged by the aborted instruction.
- `i_rst` and `i_start` asserted together: reset wins and the start is dropped.
- Counter at all-ones: the next retire wraps it to 0.

## Structure
- Shared package `datapath_pkg`: opcode and funct constants, ALU-control encodings, and the state enum.
- One sub-module, `instr_decoder`: a combinational classifier of opcode/funct into {rtype, lw, sw, addi, beq, illegal} plus the ALU code. The FSM and counter stay in the top module.

## Test plan
- Preload rN=N, then run `add` with rd=1, rs=2, rt=3. Required: `o_done` at cycle 4, WB strobe for exactly one cycle with regDst=1 and AluControl=010, and r1=5 in the datapath.
- Run `sw` then `lw` with base r4, offset 8. Required: the write strobe only in cycle 3 of sw, MemToReg=1 in lw WB, and `o_instr_count`=2.
- Run `beq` r5,r5 and then `beq` r5,r6. Required: `o_branch_taken` is 1 then 0, `o_done` at cycle 3, and no RF or memory strobe.
- Send opcode 111111. Required: `o_done` and `o_illegal` at cycle 2, no strobes, and the count is unchanged.
- Assert `i_rst` during MEM of sw. Required: the next cycle is IDLE with all outputs 0, and memory is not written after the reset edge. Also pulse `i_start` while busy: it is ignored.
- Preload the counter by running 2^CNT_W legal instructions (CNT_W=4 build). Required: `o_instr_count` wraps to 0.
